// File: rtl/hyp_cordic_iter.sv
// Iterative rotation-mode hyperbolic CORDIC: cosh(z), sinh(z) in Q2.14.
// Ports: iClk/iRst_n, iValid/oReady/iZ in, oValid/iReady/oCosh/oSinh out.
module hyp_cordic_iter #(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 14,
    parameter int NITER  = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DWIDTH-1:0] iZ,
    output logic              oValid,
    input  logic              iReady,
    output logic [DWIDTH-1:0] oCosh,
    output logic [DWIDTH-1:0] oSinh
);

    localparam int IW = $clog2(NITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 1/K_h for the repeat schedule {4,13}, pre-scaled so the result
    // comes out unity-gain
    localparam logic [DWIDTH-1:0] X0 = DWIDTH'(19784);

    // The atanh table is only valid for a Q2.14 angle format
    if (FRAC != 14) begin : g_bad_frac
        $error("hyp_cordic_iter: FRAC must be 14");
    end

    function automatic logic [DWIDTH-1:0] atanh_f(input logic [IW-1:0] i);
        int k;
        k = int'(i);
        case (k)
            1:       return DWIDTH'(9000);
            2:       return DWIDTH'(4185);
            3:       return DWIDTH'(2059);
            4:       return DWIDTH'(1025);
            5:       return DWIDTH'(512);
            6:       return DWIDTH'(256);
            default: begin
                if (k >= 7 && k <= 14) return DWIDTH'(1 << (14 - k));
                return '0;
            end
        endcase
    endfunction

    logic [1:0]               state_q, state_d;
    logic signed [DWIDTH-1:0] x_q, x_d;
    logic signed [DWIDTH-1:0] y_q, y_d;
    logic signed [DWIDTH-1:0] z_q, z_d;
    logic [IW-1:0]            i_q, i_d;
    logic                     rep_q, rep_d;

    logic signed [DWIDTH-1:0] xs, ys, at;
    logic                     neg;
    logic                     rep_pt;
    logic                     last;

    assign xs     = x_q >>> i_q;
    assign ys     = y_q >>> i_q;
    assign at     = atanh_f(i_q);
    assign neg    = z_q[DWIDTH-1];
    // First visit of a repeat index: do the step again with the same shift
    assign rep_pt = !rep_q && (i_q == IW'(4) || i_q == IW'(13));
    assign last   = (i_q == IW'(NITER)) && !rep_pt;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        rep_d   = rep_q;
        case (state_q)
            S_IDLE: begin
                if (iValid) begin
                    x_d     = X0;
                    y_d     = '0;
                    z_d     = iZ;
                    i_d     = IW'(1);
                    rep_d   = 1'b0;
                    state_d = S_ROT;
                end
            end
            S_ROT: begin
                if (neg) begin
                    x_d = x_q - ys;
                    y_d = y_q - xs;
                    z_d = z_q + at;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q + xs;
                    z_d = z_q - at;
                end
                if (rep_pt) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    i_d   = i_q + IW'(1);
                end
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                if (iReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            rep_q   <= rep_d;
        end
    end

    assign oReady = (state_q == S_IDLE);
    assign oValid = (state_q == S_DONE);
    // x/y only move in ROT or on acceptance, so they are stable in DONE
    assign oCosh  = x_q;
    assign oSinh  = y_q;

endmodule

// File: tb/tb_hyp_cordic_iter.sv
// Self-checking bench for hyp_cordic_iter.
// Scoreboard of expected cosh/sinh pushed on drive, popped on oValid.
module tb_hyp_cordic_iter;

    localparam int DW = 16;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iValid;
    logic          oReady;
    logic [DW-1:0] iZ;
    logic          oValid;
    logic          iReady;
    logic [DW-1:0] oCosh;
    logic [DW-1:0] oSinh;

    hyp_cordic_iter #(.DWIDTH(16), .FRAC(14), .NITER(16)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iZ     (iZ),
        .oValid (oValid),
        .iReady (iReady),
        .oCosh  (oCosh),
        .oSinh  (oSinh)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int cosh;
        int sinh;
        int tol;
        bit vchk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp,
                       input int tol = 0);
        int diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)",
                     tag, obs, exp, tol);
        end
    endtask

    function automatic int sv(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Wait for oReady, present z, and return once the acceptance edge passed
    task automatic start_op(input int z);
        int w;
        w = 0;
        @(negedge iClk);
        while (!oReady && w < 100) begin
            @(negedge iClk);
            w++;
        end
        if (!oReady) chk("wait_ready", 0, 1);
        iValid = 1'b1;
        iZ     = DW'(z);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        chk("busy_rdy", int'(oReady), 0);
    endtask

    task automatic run_op(input int z, input int ec, input int es,
                          input int tol, input bit vchk, input int bp);
        exp_t e;
        int   edges;
        int   hc, hs;
        q.push_back('{cosh: ec, sinh: es, tol: tol, vchk: vchk});
        start_op(z);
        edges = 0;
        while (!oValid && edges < 60) begin
            @(posedge iClk);
            #1;
            edges++;
        end
        chk("latency", edges, 18);
        e = q.pop_front();
        if (e.vchk) begin
            chk("cosh", sv(oCosh), e.cosh, e.tol);
            chk("sinh", sv(oSinh), e.sinh, e.tol);
        end
        if (bp > 0) begin
            hc = sv(oCosh);
            hs = sv(oSinh);
            for (int k = 0; k < bp; k++) begin
                @(negedge iClk);
                iValid = k[0];
                iZ     = DW'($urandom_range(0, 16384));
            end
            @(negedge iClk);
            iValid = 1'b0;
            chk("bp_valid", int'(oValid), 1);
            chk("bp_ready", int'(oReady), 0);
            chk("bp_cosh", sv(oCosh), hc);
            chk("bp_sinh", sv(oSinh), hs);
        end
        @(negedge iClk);
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        iReady = 1'b0;
        chk("rel_valid", int'(oValid), 0);
        chk("rel_ready", int'(oReady), 1);
    endtask

    initial begin
        iRst_n = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iZ     = '0;
        #12;
        chk("rst_ready", int'(oReady), 1);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_cosh", sv(oCosh), 0);
        chk("rst_sinh", sv(oSinh), 0);
        @(negedge iClk);
        iRst_n = 1'b1;

        run_op(0,      16384,  0,      2, 1'b1, 0);
        run_op(8192,   18475,  8538,   4, 1'b1, 0);
        run_op(-8192,  18475,  -8538,  4, 1'b1, 0);
        run_op(16384,  25282,  19254,  4, 1'b1, 0);
        run_op(-16384, 25282,  -19254, 4, 1'b1, 0);
        run_op(4096,   16899,  4139,   4, 1'b1, 0);
        run_op(18318,  27736,  22380,  8, 1'b1, 0);
        run_op(8192,   18475,  8538,   4, 1'b1, 25);
        // Out of range: only completion is defined
        run_op(32767,  0,      0,      0, 1'b0, 0);
        run_op(-32768, 0,      0,      0, 1'b0, 0);

        // Reset during step 7 discards the operation
        start_op(8192);
        repeat (7) @(posedge iClk);
        #3;
        iRst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(oValid), 0);
        chk("mid_rst_ready", int'(oReady), 1);
        chk("mid_rst_cosh", sv(oCosh), 0);
        chk("mid_rst_sinh", sv(oSinh), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        run_op(8192, 18475, 8538, 4, 1'b1, 0);

        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
